alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU between two requesters, e.g. the datapath and a debug/FPGA console port. Arbitrates with round-robin priority and registers the operands driven into the ALU. Captures the ALU result and flags, then returns them on a shared response bus with a per-requester done pulse. Sits between the requesters and the alu block; the ALU itself is unchanged.

Parameters:
WIDTH, 32, operand/result width (word_t)
OPW, 4, ALU opcode width (aluop field)

Ports:
CLK  in  1  system clock, all state on rising edge
nRST  in  1  synchronous active-low reset
req  in  2  request level per requester; bit i = requester i
op0  in  OPW  requester 0 opcode
a0  in  WIDTH  requester 0 port A operand
b0  in  WIDTH  requester 0 port B operand
op1  in  OPW  requester 1 opcode
a1  in  WIDTH  requester 1 port A operand
b1  in  WIDTH  requester 1 port B operand
gnt  out  2  combinational accept strobe; one-hot or zero
done  out  2  one-cycle completion pulse per requester
result  out  WIDTH  registered ALU result
zero  out  1  registered ALU zero flag
neg  out  1  registered ALU negative flag
ovf  out  1  registered ALU overflow flag
busy  out  1  high whenever state != IDLE
alu_op  out  OPW  registered opcode to ALU
alu_a  out  WIDTH  registered port A to ALU
alu_b  out  WIDTH  registered port B to ALU
alu_result  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag
alu_ovf  in  1  ALU overflow flag

Behaviour:
- Clock and reset: one clock CLK; reset nRST is synchronous, active-low, sampled only on the CLK rising edge.
- Reset values: all outputs 0. State = IDLE. Owner = 0. Last-served pointer = 1, so requester 0 wins the first tie.
- States: IDLE -> EXEC -> RESP -> IDLE. There are no other states. Unreachable encodings go to IDLE.
- IDLE, grant selection (combinational):
  - Only req0 high -> gnt=01.
  - Only req1 high -> gnt=10.
  - Both high -> grant the requester that is not the last-served one.
  - Neither high -> gnt=00.
- IDLE, acceptance: an operation is accepted at the edge where req[i] && gnt[i].
  - At that edge: latch op/a/b of the winner into alu_op/alu_a/alu_b, record owner=i, go to EXEC.
- EXEC: ALU inputs are stable from the registers; gnt=00. At the edge, capture alu_result/zero/neg/ovf into result/zero/neg/ovf, then go to RESP.
- RESP: done[owner]=1 for exactly this cycle; gnt=00. At the edge, set last-served=owner and go to IDLE.
- Latency: the accept edge is at the end of cycle N. done and valid result are seen in cycle N+2. Peak throughput is one operation per 3 cycles.
- Output hold: result and flags hold their value until the next EXEC capture. alu_* outputs hold between operations.
- Requester protocol:
  - Operands must be valid in the cycle where gnt is seen.
  - The requester may drop req or change operands after acceptance.
  - The requester must not re-request before its done.
  - req held high in RESP is ignored. It is re-evaluated in the following IDLE cycle.
- Fairness: with both req held continuously, grants strictly alternate 0,1,0,1...
- No interpretation of flags: overflow and sign are passed through as computed by the ALU. The arbiter never modifies the result.
- Reset mid-operation: nRST low in EXEC or RESP returns to IDLE. No done is issued, and result/flags clear to 0.
- Invariants:
  - gnt and done are never both non-zero.
  - done is at most one-hot.
  - busy=0 exactly when state=IDLE.

Test Plan:
- Reset, then a single request:
  - Stimulus: after reset, req=01, op0=ADD, a0=5, b0=7.
  - Response: gnt=01 in the first cycle; done=01 two cycles later; result=12, zero=0, neg=0, ovf=0.
- Simultaneous requests (first tie):
  - Stimulus: req=11 in IDLE; requester 0 SUB 3-3, requester 1 ADD 1+1.
  - Response: requester 0 is served first with result=0, zero=1. Requester 1 is served next with result=2. The gap between done pulses is exactly 3 cycles.
- Continuous contention:
  - Stimulus: both req held for 6 operations.
  - Response: grant order is 0,1,0,1,0,1 and busy never drops for more than 1 cycle.
- Flag pass-through:
  - Stimulus: requester 1 ADD 0x7FFFFFFF+1.
  - Response: result=0x80000000, neg=1, ovf=1, done=10. result holds its value through the following idle cycles.
- Reset mid-operation:
  - Stimulus: nRST low during EXEC.
  - Response: no done pulse; next cycle state=IDLE, busy=0, result=0. A subsequent req=10 is granted immediately.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared combinational ALU.
// slave = arbiter view, master = requesters plus ALU (the other side of every wire).
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  // requester side
  logic [1:0]       req;
  logic [OPW-1:0]   op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             zero, neg, ovf;
  logic             busy;
  // ALU side
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_neg, alu_ovf;

  modport slave (
    input  req, op0, a0, b0, op1, a1, b1,
    input  alu_result, alu_zero, alu_neg, alu_ovf,
    output gnt, done, result, zero, neg, ovf, busy,
    output alu_op, alu_a, alu_b
  );

  modport master (
    output req, op0, a0, b0, op1, a1, b1,
    output alu_result, alu_zero, alu_neg, alu_ovf,
    input  gnt, done, result, zero, neg, ovf, busy,
    input  alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation per 3 cycles: IDLE (grant/accept) -> EXEC (ALU settles) -> RESP (done).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           r_state, w_next;
  logic             r_owner;   // requester of the operation in flight
  logic             r_last;    // last-served requester; loses the next tie
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_neg, r_ovf;

  logic             w_win;     // requester that would be granted this cycle
  logic             w_accept;
  logic [1:0]       w_gnt, w_done;
  logic             w_busy;

  // per-requester operand views, indexed by requester number
  logic [1:0][OPW-1:0]   w_op;
  logic [1:0][WIDTH-1:0] w_a, w_b;
  assign w_op = {bus.op1, bus.op0};
  assign w_a  = {bus.a1,  bus.a0};
  assign w_b  = {bus.b1,  bus.b0};

  // round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_win = 1'b0;
    case (bus.req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  assign w_accept = (r_state == IDLE) && (bus.req != 2'b00);

  // state register
  always_ff @(posedge CLK) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state; the spare encoding falls back to IDLE
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_accept ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state-decoded outputs: grant only while idle, done only in RESP
  always_comb begin
    w_gnt  = 2'b00;
    w_done = 2'b00;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.req != 2'b00) w_gnt = w_win ? 2'b10 : 2'b01;
      end
      RESP:    w_done = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // operand latch at accept, result capture in EXEC, pointer update in RESP
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner  <= w_win;
        r_alu_op <= w_op[w_win];
        r_alu_a  <= w_a[w_win];
        r_alu_b  <= w_b[w_win];
      end
      if (r_state == EXEC) begin
        r_result <= bus.alu_result;
        r_zero   <= bus.alu_zero;
        r_neg    <= bus.alu_neg;
        r_ovf    <= bus.alu_ovf;
      end
      if (r_state == RESP) r_last <= r_owner;
    end
  end

  assign bus.gnt    = w_gnt;
  assign bus.done   = w_done;
  assign bus.busy   = w_busy;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.neg    = r_neg;
  assign bus.ovf    = r_ovf;
  assign bus.alu_op = r_alu_op;
  assign bus.alu_a  = r_alu_a;
  assign bus.alu_b  = r_alu_b;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-timed model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alu_arbiter;
  localparam int W   = 32;
  localparam int OPW = 4;
  localparam logic [OPW-1:0] OP_ADD = 4'd0;
  localparam logic [OPW-1:0] OP_SUB = 4'd1;
  localparam logic [OPW-1:0] OP_AND = 4'd2;
  localparam logic [OPW-1:0] OP_OR  = 4'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  alu_arbiter_if #(.WIDTH(W), .OPW(OPW)) bus();

  alu_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // reference ALU, returns {ovf, neg, zero, result}
  function automatic logic [W+2:0] alu_f(input logic [OPW-1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SUB: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = a ^ b;
    endcase
    return {v, r[W-1], (r == '0), r};
  endfunction

  // the ALU the arbiter drives
  assign {bus.alu_ovf, bus.alu_neg, bus.alu_zero, bus.alu_result} =
         alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model: timestamps of grants and completions ----------------
  int             m_free_at = 0;   // first cycle a new grant may be given
  int             m_last    = 1;   // requester served most recently
  int             m_due     = -1;  // cycle in which the pending done appears
  int             m_own     = 0;
  logic [W+2:0]   m_pend    = '0;
  logic [W+2:0]   m_held    = '0;  // {ovf,neg,zero,result} currently visible
  logic [OPW-1:0] m_op      = '0;
  logic [W-1:0]   m_a       = '0;
  logic [W-1:0]   m_b       = '0;

  // compare DUT against the model every cycle, then advance the model
  always @(negedge CLK) begin
    logic [1:0] e_gnt, e_done;
    logic       e_busy;
    int         win;
    e_busy = (cyc < m_free_at);
    e_gnt  = 2'b00;
    win    = 0;
    if (!e_busy && bus.req != 2'b00) begin
      if (bus.req == 2'b11) win = 1 - m_last;
      else                  win = (bus.req == 2'b10) ? 1 : 0;
      e_gnt = 2'b01 << win;
    end
    e_done = (cyc == m_due) ? (2'b01 << m_own) : 2'b00;
    if (cyc == m_due) m_held = m_pend;

    chk("m.gnt",    bus.gnt,    e_gnt);
    chk("m.done",   bus.done,   e_done);
    chk("m.busy",   bus.busy,   e_busy);
    chk("m.result", bus.result, m_held[W-1:0]);
    chk("m.flags",  {bus.ovf, bus.neg, bus.zero}, m_held[W+2:W]);
    chk("m.alu_op", bus.alu_op, m_op);
    chk("m.alu_a",  bus.alu_a,  m_a);
    chk("m.alu_b",  bus.alu_b,  m_b);
    chk("m.gnt_done_excl", (bus.gnt != 2'b00) && (bus.done != 2'b00), 1'b0);

    if (!nRST) begin
      m_free_at = cyc + 1;
      m_last    = 1;
      m_due     = -1;
      m_held    = '0;
      m_op      = '0;
      m_a       = '0;
      m_b       = '0;
    end else if (e_gnt != 2'b00) begin
      m_own     = win;
      m_op      = win ? bus.op1 : bus.op0;
      m_a       = win ? bus.a1  : bus.a0;
      m_b       = win ? bus.b1  : bus.b0;
      m_pend    = alu_f(m_op, m_a, m_b);
      m_due     = cyc + 2;
      m_free_at = cyc + 3;
      m_last    = win;
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // waits for done[who]; returns cycles elapsed, or -1 on timeout
  task automatic wait_done(input int who, output int dt);
    dt = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bus.done[who]) begin
        dt = k + 1;
        break;
      end
    end
    if (dt < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done%0d: no done within 20 cycles, required one", who);
    end
  endtask

  initial begin
    int dt;
    int maxlow, curlow;
    int order[$];

    bus.req = 2'b00;
    bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
    bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;
    nRST = 1'b0;
    step(); step();
    nRST = 1'b1;

    // reset state
    @(negedge CLK);
    chk("rst.result", bus.result, 0);
    chk("rst.busy",   bus.busy,   0);
    chk("rst.gnt",    bus.gnt,    0);
    chk("rst.alu_a",  bus.alu_a,  0);

    // single request: 5 + 7
    step();
    bus.op0 = OP_ADD; bus.a0 = 32'd5; bus.b0 = 32'd7; bus.req = 2'b01;
    @(negedge CLK);
    chk("t1.gnt", bus.gnt, 2'b01);
    step();
    bus.req = 2'b00;
    wait_done(0, dt);
    chk("t1.latency", dt, 2);
    chk("t1.done",    bus.done, 2'b01);
    chk("t1.result",  bus.result, 32'd12);
    chk("t1.flags",   {bus.ovf, bus.neg, bus.zero}, 3'b000);

    // fresh reset, then first tie: 0 wins, 1 follows three cycles later
    step(); nRST = 1'b0;
    step(); nRST = 1'b1;
    bus.op0 = OP_SUB; bus.a0 = 32'd3; bus.b0 = 32'd3;
    bus.op1 = OP_ADD; bus.a1 = 32'd1; bus.b1 = 32'd1;
    bus.req = 2'b11;
    @(negedge CLK);
    chk("t2.gnt", bus.gnt, 2'b01);
    step();
    bus.req = 2'b10;
    wait_done(0, dt);
    chk("t2.done0",   bus.done, 2'b01);
    chk("t2.result0", bus.result, 32'd0);
    chk("t2.zero0",   bus.zero, 1'b1);
    wait_done(1, dt);
    chk("t2.gap",     dt, 3);
    chk("t2.done1",   bus.done, 2'b10);
    chk("t2.result1", bus.result, 32'd2);
    chk("t2.zero1",   bus.zero, 1'b0);
    step();
    bus.req = 2'b00;

    // continuous contention for 6 operations
    bus.op0 = OP_ADD; bus.a0 = 32'd10;  bus.b0 = 32'd20;
    bus.op1 = OP_OR;  bus.a1 = 32'hF0;  bus.b1 = 32'h0F;
    step();
    bus.req = 2'b11;
    maxlow = 0; curlow = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!bus.busy) begin curlow++; if (curlow > maxlow) maxlow = curlow; end
      else curlow = 0;
      if (bus.gnt != 2'b00) order.push_back(bus.gnt == 2'b10 ? 1 : 0);
      if (order.size() == 6) break;
    end
    step();
    bus.req = 2'b00;
    chk("t3.count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      int got;
      got = (i < order.size()) ? order[i] : -1;
      chk($sformatf("t3.order%0d", i), got, i % 2);
    end
    chk("t3.busy_gap", maxlow <= 1, 1'b1);
    wait_done(1, dt);
    chk("t3.last_result", bus.result, 32'hFF);
    step();

    // flag pass-through: 0x7FFFFFFF + 1
    bus.op1 = OP_ADD; bus.a1 = 32'h7FFF_FFFF; bus.b1 = 32'd1; bus.req = 2'b10;
    @(negedge CLK);
    chk("t4.gnt", bus.gnt, 2'b10);
    step();
    bus.req = 2'b00;
    wait_done(1, dt);
    chk("t4.done",   bus.done, 2'b10);
    chk("t4.result", bus.result, 32'h8000_0000);
    chk("t4.flags",  {bus.ovf, bus.neg, bus.zero}, 3'b110);
    step(); step(); step();
    @(negedge CLK);
    chk("t4.hold", bus.result, 32'h8000_0000);

    // reset during EXEC
    step();
    bus.op0 = OP_ADD; bus.a0 = 32'd1; bus.b0 = 32'd2; bus.req = 2'b01;
    @(negedge CLK);
    chk("t5.gnt", bus.gnt, 2'b01);
    step();
    bus.req = 2'b00; nRST = 1'b0;
    @(negedge CLK);
    chk("t5.exec_busy", bus.busy, 1'b1);
    chk("t5.exec_done", bus.done, 2'b00);
    step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("t5.busy",   bus.busy, 1'b0);
    chk("t5.done",   bus.done, 2'b00);
    chk("t5.result", bus.result, 32'd0);
    step();
    bus.op1 = OP_ADD; bus.a1 = 32'd4; bus.b1 = 32'd4; bus.req = 2'b10;
    @(negedge CLK);
    chk("t5.regnt", bus.gnt, 2'b10);
    step();
    bus.req = 2'b00;
    wait_done(1, dt);
    chk("t5.result8", bus.result, 32'd8);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
